// File: rtl/move_input_pkg.sv
// Shared constants for the PS/2 move decoder: scancodes, direction bit
// positions, held-key indices and the frame receiver state encoding.
package move_input_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_START = 8'h1B;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  // Held bits reuse the direction positions; the S key sits above them.
  localparam int HELD_START = 4;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  function automatic logic [4:0] key_mask(input logic [7:0] code, input logic ext);
    logic [4:0] m;
    m = '0;
    if (ext) begin
      case (code)
        SC_UP:    m[DIR_UP]    = 1'b1;
        SC_DOWN:  m[DIR_DOWN]  = 1'b1;
        SC_LEFT:  m[DIR_LEFT]  = 1'b1;
        SC_RIGHT: m[DIR_RIGHT] = 1'b1;
        default:  m = '0;
      endcase
    end else if (code == SC_START) begin
      m[HELD_START] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/move_input_if.sv
// Move handshake between the keyboard decoder (master) and game control (slave).
interface move_input_if;
  logic       move_ack;
  logic [3:0] direction;
  logic       move_valid;
  logic       start_pulse;
  logic       frame_err;

  modport master (
    input  move_ack,
    output direction,
    output move_valid,
    output start_pulse,
    output frame_err
  );

  modport slave (
    output move_ack,
    input  direction,
    input  move_valid,
    input  start_pulse,
    input  frame_err
  );
endinterface

// File: rtl/move_input_ps2_rx.sv
// PS/2 frame receiver: synchronizers, 11-bit frame FSM, odd-parity/stop
// check and an idle timeout that abandons partial frames.
//
// state     | meaning
// RX_IDLE   | waiting for a start bit (falling edge with data 0)
// RX_DATA   | shifting 8 data bits, LSB first
// RX_PARITY | capturing the parity bit
// RX_STOP   | checking the stop bit and parity, then back to idle
module ps2_rx
  import move_input_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic clk_s1, clk_s2, clk_q;
  logic dat_s1, dat_s2;
  logic fall;

  rx_state_t     state, state_nx;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic          parity_bit;
  logic [TW-1:0] timer;
  logic          frame_ok, frame_bad, timed_out;

  assign fall = clk_q & ~clk_s2;

  always_comb begin
    state_nx  = state;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    timed_out = (state != RX_IDLE) && !fall && (timer == '0);
    if (timed_out) begin
      state_nx  = RX_IDLE;
      frame_bad = 1'b1;
    end else if (fall) begin
      case (state)
        RX_IDLE:   if (!dat_s2) state_nx = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) state_nx = RX_PARITY;
        RX_PARITY: state_nx = RX_STOP;
        RX_STOP: begin
          state_nx = RX_IDLE;
          if ((^{shift_reg, parity_bit}) && dat_s2) frame_ok  = 1'b1;
          else                                      frame_bad = 1'b1;
        end
        default:   state_nx = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      clk_q      <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      state      <= RX_IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      timer      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      clk_q      <= clk_s2;
      dat_s1     <= ps2_dat;
      dat_s2     <= dat_s1;
      state      <= state_nx;
      byte_valid <= frame_ok;
      frame_err  <= frame_bad;

      // Reloaded on every edge so only a silent bus counts toward the timeout.
      if (fall)
        timer <= T_LOAD;
      else if (state != RX_IDLE && timer != '0)
        timer <= timer - TW'(1);

      if (fall && state == RX_DATA) begin
        shift_reg <= {dat_s2, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
      if (state_nx == RX_IDLE)
        bit_cnt <= '0;

      if (fall && state == RX_PARITY)
        parity_bit <= dat_s2;

      if (frame_ok)
        rx_byte <= shift_reg;
    end
  end

endmodule

// File: rtl/move_input.sv
// Keyboard-to-game move decoder: receives PS/2 bytes, tracks extended/break
// prefixes and held keys, and offers one pending move at a time.
module move_input
  import move_input_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         ps2_clk,
  input  logic         ps2_dat,
  move_input_if.master m
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  logic       ext, brk;
  logic [4:0] held;
  logic [4:0] mask;
  logic [3:0] dir_r;
  logic       move_valid_r;
  logic       start_pulse_r;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock     (clock),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .rx_byte   (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_err)
  );

  always_comb begin
    mask = key_mask(rx_byte, ext);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ext           <= 1'b0;
      brk           <= 1'b0;
      held          <= '0;
      dir_r         <= '0;
      move_valid_r  <= 1'b0;
      start_pulse_r <= 1'b0;
    end else begin
      start_pulse_r <= 1'b0;

      if (move_valid_r && m.move_ack) begin
        move_valid_r <= 1'b0;
        dir_r        <= '0;
      end

      if (rx_valid) begin
        if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (brk) begin
            held <= held & ~mask;
          end else if (mask != '0 && (held & mask) == '0) begin
            held <= held | mask;
            // A move arriving while one is pending (even one being acked now) is dropped.
            if (mask[HELD_START]) begin
              start_pulse_r <= 1'b1;
            end else if (!move_valid_r) begin
              dir_r        <= mask[3:0];
              move_valid_r <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign m.direction   = dir_r;
  assign m.move_valid  = move_valid_r;
  assign m.start_pulse = start_pulse_r;
  assign m.frame_err   = rx_err;

endmodule

// File: tb/tb_move_input.sv
// Directed bench for move_input: single-key vector table plus hand sequences
// for repeat, break, parity error, timeout and mid-frame reset.
module tb_move_input;
  import move_input_pkg::*;

  localparam int TB_TIMEOUT = 300;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  move_input_if m ();

  move_input #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clock  (clock),
    .resetn (resetn),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .m      (m.master)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int start_cnt = 0, err_cnt = 0, rise_cnt = 0;
  logic [3:0] last_dir = '0;
  logic mv_prev = 1'b0;

  always @(negedge clock) begin
    if (m.start_pulse) start_cnt++;
    if (m.frame_err) err_cnt++;
    if (m.move_valid && !mv_prev) begin
      rise_cnt++;
      last_dir = m.direction;
    end
    mv_prev = m.move_valid;
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    wait_cyc(4);
    ps2_clk = 1'b0;
    wait_cyc(8);
    ps2_clk = 1'b1;
    wait_cyc(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    ps2_dat = 1'b1;
    wait_cyc(20);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    ps2_dat = 1'b1;
  endtask

  task automatic ack_move();
    @(negedge clock);
    m.move_ack = 1'b1;
    @(negedge clock);
    m.move_ack = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic       ext;
    logic [7:0] code;
    logic [3:0] exp_dir;
    int         exp_start;
  } vec_t;

  vec_t vecs[8];
  int r0, s0, e0;
  int unstable;

  initial begin
    m.move_ack = 1'b0;
    vecs[0] = '{"up",       1'b1, 8'h75, 4'b1000, 0};
    vecs[1] = '{"down",     1'b1, 8'h72, 4'b0100, 0};
    vecs[2] = '{"left",     1'b1, 8'h6B, 4'b0010, 0};
    vecs[3] = '{"right",    1'b1, 8'h74, 4'b0001, 0};
    vecs[4] = '{"start",    1'b0, 8'h1B, 4'b0000, 1};
    vecs[5] = '{"kp8",      1'b0, 8'h75, 4'b0000, 0};
    vecs[6] = '{"ext_s",    1'b1, 8'h1B, 4'b0000, 0};
    vecs[7] = '{"unmapped", 1'b0, 8'h1C, 4'b0000, 0};

    resetn = 1'b0;
    wait_cyc(3);
    @(negedge clock);
    check("rst_direction", int'(m.direction), 0);
    check("rst_move_valid", int'(m.move_valid), 0);
    check("rst_start_pulse", int'(m.start_pulse), 0);
    check("rst_frame_err", int'(m.frame_err), 0);
    resetn = 1'b1;
    wait_cyc(5);

    for (int i = 0; i < 8; i++) begin
      r0 = rise_cnt; s0 = start_cnt; e0 = err_cnt;
      if (vecs[i].ext) send_byte(SC_EXT, 1'b0);
      send_byte(vecs[i].code, 1'b0);
      @(negedge clock);
      check({vecs[i].name, "_rises"}, rise_cnt - r0, (vecs[i].exp_dir != 0) ? 1 : 0);
      check({vecs[i].name, "_valid"}, int'(m.move_valid), (vecs[i].exp_dir != 0) ? 1 : 0);
      check({vecs[i].name, "_dir"}, int'(m.direction), int'(vecs[i].exp_dir));
      check({vecs[i].name, "_start"}, start_cnt - s0, vecs[i].exp_start);
      check({vecs[i].name, "_err"}, err_cnt - e0, 0);
      if (m.move_valid) ack_move();
      if (vecs[i].ext) send_byte(SC_EXT, 1'b0);
      send_byte(SC_BRK, 1'b0);
      send_byte(vecs[i].code, 1'b0);
    end

    // Held move stays stable until acked, then clears one cycle later.
    send_byte(SC_EXT, 1'b0);
    send_byte(SC_UP, 1'b0);
    unstable = 0;
    repeat (100) begin
      @(negedge clock);
      if (m.move_valid !== 1'b1 || m.direction !== 4'b1000) unstable++;
    end
    check("hold_unstable_cycles", unstable, 0);
    ack_move();
    check("ack_valid_cleared", int'(m.move_valid), 0);
    check("ack_dir_cleared", int'(m.direction), 0);
    send_byte(SC_EXT, 1'b0); send_byte(SC_BRK, 1'b0); send_byte(SC_UP, 1'b0);

    // Typematic repeat yields one move; a break re-arms the key.
    r0 = rise_cnt;
    send_byte(SC_EXT, 1'b0); send_byte(SC_LEFT, 1'b0);
    send_byte(SC_EXT, 1'b0); send_byte(SC_LEFT, 1'b0);
    ack_move();
    wait_cyc(50);
    check("repeat_rises", rise_cnt - r0, 1);
    check("repeat_dir", int'(last_dir), 4'b0010);
    check("repeat_after_ack_valid", int'(m.move_valid), 0);
    send_byte(SC_EXT, 1'b0); send_byte(SC_BRK, 1'b0); send_byte(SC_LEFT, 1'b0);
    r0 = rise_cnt;
    send_byte(SC_EXT, 1'b0); send_byte(SC_LEFT, 1'b0);
    @(negedge clock);
    check("rearm_rises", rise_cnt - r0, 1);
    check("rearm_dir", int'(m.direction), 4'b0010);
    ack_move();
    send_byte(SC_EXT, 1'b0); send_byte(SC_BRK, 1'b0); send_byte(SC_LEFT, 1'b0);

    // Start pulse is one cycle, no repeat while held; does not disturb a pending move.
    send_byte(SC_EXT, 1'b0); send_byte(SC_DOWN, 1'b0);
    s0 = start_cnt;
    send_byte(SC_START, 1'b0);
    check("start_cycles", start_cnt - s0, 1);
    @(negedge clock);
    check("start_keeps_move", int'(m.direction), 4'b0100);
    s0 = start_cnt;
    send_byte(SC_START, 1'b0);
    check("start_repeat_cycles", start_cnt - s0, 0);
    ack_move();
    send_byte(SC_BRK, 1'b0); send_byte(SC_START, 1'b0);
    send_byte(SC_EXT, 1'b0); send_byte(SC_BRK, 1'b0); send_byte(SC_DOWN, 1'b0);

    // Bad parity frame is dropped with one error pulse.
    r0 = rise_cnt; e0 = err_cnt;
    send_byte(SC_UP, 1'b1);
    check("parity_err_pulses", err_cnt - e0, 1);
    check("parity_no_move", rise_cnt - r0, 0);
    send_byte(SC_EXT, 1'b0); send_byte(SC_RIGHT, 1'b0);
    @(negedge clock);
    check("after_parity_dir", int'(m.direction), 4'b0001);
    ack_move();
    send_byte(SC_EXT, 1'b0); send_byte(SC_BRK, 1'b0); send_byte(SC_RIGHT, 1'b0);

    // Partial frame abandoned after the idle timeout.
    e0 = err_cnt; r0 = rise_cnt;
    send_partial(SC_EXT, 5);
    wait_cyc(TB_TIMEOUT + 1 + 10);
    check("timeout_err_pulses", err_cnt - e0, 1);
    send_byte(SC_EXT, 1'b0); send_byte(SC_DOWN, 1'b0);
    @(negedge clock);
    check("after_timeout_dir", int'(m.direction), 4'b0100);
    check("after_timeout_err", err_cnt - e0, 1);
    check("after_timeout_rises", rise_cnt - r0, 1);
    ack_move();
    send_byte(SC_EXT, 1'b0); send_byte(SC_BRK, 1'b0); send_byte(SC_DOWN, 1'b0);

    // Reset in mid-frame, then a clean frame with no error.
    e0 = err_cnt;
    send_partial(SC_EXT, 4);
    resetn = 1'b0;
    wait_cyc(1);
    resetn = 1'b1;
    wait_cyc(10);
    send_byte(SC_EXT, 1'b0); send_byte(SC_UP, 1'b0);
    @(negedge clock);
    check("midreset_dir", int'(m.direction), 4'b1000);
    check("midreset_valid", int'(m.move_valid), 1);
    wait_cyc(TB_TIMEOUT + 20);
    check("midreset_err", err_cnt - e0, 0);
    ack_move();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/move_input.md
MOVE_INPUT -- requirements
Module: move_input

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 50000, the idle CLOCK cycles after which a partial PS/2 frame is abandoned (1 ms at 50 MHz).
REQ-002 Port: clock  in  1  system clock (50 MHz); all logic on its rising edge.
REQ-003 Port: resetn  in  1  synchronous, active-low reset.
REQ-004 Port: ps2_clk  in  1  raw PS/2 keyboard clock, asynchronous.
REQ-005 Port: ps2_dat  in  1  raw PS/2 keyboard data, asynchronous.
REQ-006 Port: move_ack  in  1  consumer (game control) accepts the pending move.
REQ-007 Port: direction  out  4  one-hot move: [3] up, [2] down, [1] left, [0] right; 0 = none.
REQ-008 Port: move_valid  out  1  direction holds a pending move.
REQ-009 Port: start_pulse  out  1  one-cycle request to start or reset the game.
REQ-010 Port: frame_err  out  1  one-cycle flag: a frame was discarded.

Function
REQ-011 ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer; a falling edge is synced-clock 1 in the prior cycle and 0 in this one.
REQ-012 The frame FSM SHALL have states IDLE, DATA, PARITY, STOP; it samples synced data on each falling edge.
REQ-013 IDLE -> DATA on a falling edge with data 0; a falling edge with data 1 in IDLE is ignored.
REQ-014 DATA SHALL shift 8 bits LSB first, then go to PARITY; PARITY then goes to STOP; STOP then goes to IDLE.
REQ-015 A byte SHALL be valid only if the 8 data bits plus the parity bit have an odd count of ones and the stop bit is 1; otherwise the byte is dropped and frame_err pulses.
REQ-016 In any state other than IDLE, TIMEOUT_CYCLES cycles with no falling edge SHALL force IDLE, drop the partial byte, and pulse frame_err.
REQ-017 The decoder SHALL keep flags ext and brk: byte 0xE0 sets ext; byte 0xF0 sets brk; any other valid byte is a key code and clears both flags after it is used.
REQ-018 Key map, matched only with ext=1: 0x75 up, 0x72 down, 0x6B left, 0x74 right. Key map, matched only with ext=0: 0x1B is the S key (start).
REQ-019 A key code with brk=0 is a make; with brk=1 it is a break, which clears that key's held bit and produces no output.
REQ-020 Each of the five mapped keys SHALL have a held bit; a make for a key that is already held (typematic repeat) produces no output.
REQ-021 A make for a direction key that is not held SHALL set its held bit. If move_valid=0, it also loads direction and sets move_valid on the next cycle. If move_valid=1, the move is dropped.
REQ-022 move_valid and direction SHALL stay stable until a cycle with move_ack=1; the next cycle they both go to 0.
REQ-023 If move_ack and a new accepted make occur in the same cycle, the new move SHALL be dropped; no back-to-back overwrite is allowed.
REQ-024 A make for S that is not held SHALL pulse start_pulse for exactly one cycle, independent of move_valid; it does not clear a pending move.
REQ-025 Unmapped key codes SHALL clear ext and brk and produce no output.
REQ-026 Latency: move_valid rises exactly 2 cycles after the falling edge that samples the stop bit (1 cycle to register the byte, 1 cycle to decode).

Reset
REQ-027 While resetn=0 at a clock edge: frame FSM -> IDLE; shift register, bit counter, and timeout counter -> 0; ext, brk, and all held bits -> 0; synchronizers -> 1 (bus idle).
REQ-028 While resetn=0 at a clock edge, the outputs SHALL be: direction=0, move_valid=0, start_pulse=0, frame_err=0.
REQ-029 Reset in the middle of a frame SHALL abandon it; the next frame is received correctly with no error pulse.

Structure
REQ-030 A shared package SHALL hold: scancode constants (0xE0, 0xF0, 0x75, 0x72, 0x6B, 0x74, 0x1B), the direction bit indices, and the frame FSM state encoding.
REQ-031 The frame receiver (synchronizers, frame FSM, parity/stop check, timeout) SHALL be a sub-module ps2_rx. It outputs byte[7:0], byte_valid, and frame_err; move_input instantiates it and adds the decoder and output handshake.

Verification
REQ-032 Frames E0, 75 with move_ack held 0 -> direction=4'b1000 and move_valid=1, stable for 100 cycles; move_ack=1 for one cycle -> both cleared the next cycle.
REQ-033 Frames E0, 6B, then E0, 6B again (no break), then ack -> exactly one move, 4'b0010. Then frames E0, F0, 6B, then E0, 6B -> second move 4'b0010.
REQ-034 Frame 1B -> start_pulse high for exactly 1 cycle. Repeated 1B with no break -> no further pulse.
REQ-035 Frame 0x75 sent with even parity -> frame_err pulses once, no move. A following correct E0, 74 -> 4'b0001.
REQ-036 Stop after 5 data bits, wait TIMEOUT_CYCLES+1 cycles -> frame_err pulses once, FSM returns to IDLE. Then E0, 72 -> 4'b0100.
REQ-037 resetn=0 for 1 cycle in the middle of the E0 frame, then E0, 75 -> 4'b1000; no frame_err at any point.
